power_pack_mgr: RTL and testbench

- Multi-slot power-up manager for the Pong playfield. Generalises the single power pack to NUM_SLOTS independent packs.
- Each slot has a spawn/lifetime/respawn state machine, randomised clamped placement and mode, and ball-collision pickup.
- Grants a timed effect (mode + countdown) to the player who last hit the ball.
- Sits between the game FSM/ball logic and the VGA pixel mux.

---
 rtl/power_pack_mgr.sv | 216 +++++++++++++++++++++
 tb/tb_power_pack_mgr.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/power_pack_mgr.sv
`default_nettype none
// ============================================================================
// Module   : power_pack_mgr
// Brief    : Multi-slot power-up manager. Spawns, times out and detects pickup
//            of NUM_SLOTS packs, grants timed effects and draws the packs.
// Revision : 1.0
// ============================================================================
module power_pack_mgr #(
    parameter int NUM_SLOTS     = 2,
    parameter int WIDTH         = 20,
    parameter int HEIGHT        = 20,
    parameter int H_RES         = 1024,
    parameter int V_RES         = 768,
    parameter int LIFETIME      = 600,
    parameter int RESPAWN_DELAY = 120,
    parameter int EFFECT_FRAMES = 300
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic [20:0] rand_in,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic [10:0] ball_x,
    input  logic [9:0]  ball_y,
    input  logic [5:0]  ball_size,
    input  logic        last_hitter,
    output logic [7:0]  pixel,
    output logic [1:0]  eff_active,
    output logic [3:0]  eff_mode,
    output logic [1:0]  grant_pulse
);
    localparam int c_RESP_W  = $clog2(RESPAWN_DELAY + 1);
    localparam int c_LIFE_W  = $clog2(LIFETIME + 1);
    localparam int c_EFF_W   = $clog2(EFFECT_FRAMES + 1);
    localparam int c_STAGGER = RESPAWN_DELAY / NUM_SLOTS;

    localparam logic [1:0] c_S_WAIT  = 2'd0;
    localparam logic [1:0] c_S_SPAWN = 2'd1;
    localparam logic [1:0] c_S_LIVE  = 2'd2;

    logic [1:0]          r_state [NUM_SLOTS];
    logic [c_RESP_W-1:0] r_cnt   [NUM_SLOTS];
    logic [c_LIFE_W-1:0] r_life  [NUM_SLOTS];
    logic [10:0]         r_rx    [NUM_SLOTS];
    logic [9:0]          r_ry    [NUM_SLOTS];
    logic [1:0]          r_mode  [NUM_SLOTS];

    logic [1:0]          w_state_nxt [NUM_SLOTS];
    logic [c_RESP_W-1:0] w_cnt_nxt   [NUM_SLOTS];
    logic [c_LIFE_W-1:0] w_life_nxt  [NUM_SLOTS];
    logic [10:0]         w_rx_nxt    [NUM_SLOTS];
    logic [9:0]          w_ry_nxt    [NUM_SLOTS];
    logic [1:0]          w_mode_nxt  [NUM_SLOTS];

    logic [NUM_SLOTS-1:0] w_hit;
    logic [NUM_SLOTS-1:0] w_cover;
    logic                 w_spawn_busy;
    logic                 w_grant;
    logic [1:0]           w_grant_mode;
    logic [7:0]           w_pix;

    logic [c_EFF_W-1:0]   r_timer [2];
    logic [3:0]           r_eff_mode;
    logic [1:0]           r_grant_pulse;
    logic [7:0]           r_pixel;

    logic [10:0] w_rx_raw, w_rx_new;
    logic [9:0]  w_ry_raw, w_ry_new;

    // Out-of-range coordinates fold back by half the screen
    assign w_rx_raw = rand_in[20:10];
    assign w_ry_raw = rand_in[9:0];
    assign w_rx_new = (w_rx_raw > 11'(H_RES - WIDTH))  ? w_rx_raw - 11'(H_RES / 2) : w_rx_raw;
    assign w_ry_new = (w_ry_raw > 10'(V_RES - HEIGHT)) ? w_ry_raw - 10'(V_RES / 2) : w_ry_raw;

    function automatic logic [7:0] mode_color(input logic [1:0] mode);
        case (mode)
            2'b00:   mode_color = 8'b000_000_11;
            2'b01:   mode_color = 8'b000_101_10;
            2'b10:   mode_color = 8'b111_000_11;
            default: mode_color = 8'b111_100_00;
        endcase
    endfunction

    generate
        for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
            logic [11:0] w_x_lo, w_x_hi, w_bx_lo, w_bx_hi, w_hc;
            logic [10:0] w_y_lo, w_y_hi, w_by_lo, w_by_hi, w_vc;
            assign w_x_lo  = {1'b0, r_rx[g]};
            assign w_x_hi  = w_x_lo + 12'(WIDTH);
            assign w_y_lo  = {1'b0, r_ry[g]};
            assign w_y_hi  = w_y_lo + 11'(HEIGHT);
            assign w_bx_lo = {1'b0, ball_x};
            assign w_bx_hi = w_bx_lo + {6'd0, ball_size};
            assign w_by_lo = {1'b0, ball_y};
            assign w_by_hi = w_by_lo + {5'd0, ball_size};
            assign w_hc    = {1'b0, hcount};
            assign w_vc    = {1'b0, vcount};
            assign w_hit[g]   = (w_bx_lo < w_x_hi) && (w_bx_hi > w_x_lo) &&
                                (w_by_lo < w_y_hi) && (w_by_hi > w_y_lo);
            assign w_cover[g] = (r_state[g] == c_S_LIVE) &&
                                (w_hc >= w_x_lo) && (w_hc < w_x_hi) &&
                                (w_vc >= w_y_lo) && (w_vc < w_y_hi);
        end
    endgenerate

    // Slot FSMs; lower indices claim the shared random word and the grant first
    always_comb begin
        w_spawn_busy = 1'b0;
        w_grant      = 1'b0;
        w_grant_mode = 2'b00;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            w_life_nxt[i]  = r_life[i];
            w_rx_nxt[i]    = r_rx[i];
            w_ry_nxt[i]    = r_ry[i];
            w_mode_nxt[i]  = r_mode[i];
            case (r_state[i])
                c_S_WAIT: begin
                    if (r_cnt[i] == '0)
                        w_state_nxt[i] = c_S_SPAWN;
                    else if (frame_tick)
                        w_cnt_nxt[i] = r_cnt[i] - c_RESP_W'(1);
                end
                c_S_SPAWN: begin
                    if (!w_spawn_busy) begin
                        w_spawn_busy   = 1'b1;
                        w_mode_nxt[i]  = rand_in[1:0];
                        w_rx_nxt[i]    = w_rx_new;
                        w_ry_nxt[i]    = w_ry_new;
                        w_life_nxt[i]  = c_LIFE_W'(LIFETIME);
                        w_state_nxt[i] = c_S_LIVE;
                    end
                end
                c_S_LIVE: begin
                    if (frame_tick) begin
                        if (w_hit[i]) begin
                            w_state_nxt[i] = c_S_WAIT;
                            w_cnt_nxt[i]   = c_RESP_W'(RESPAWN_DELAY);
                            if (!w_grant) begin
                                w_grant      = 1'b1;
                                w_grant_mode = r_mode[i];
                            end
                        end else if (r_life[i] <= c_LIFE_W'(1)) begin
                            w_state_nxt[i] = c_S_WAIT;
                            w_cnt_nxt[i]   = c_RESP_W'(RESPAWN_DELAY);
                        end else begin
                            w_life_nxt[i] = r_life[i] - c_LIFE_W'(1);
                        end
                    end
                end
                default: w_state_nxt[i] = c_S_WAIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!reset) begin
                r_state[i] <= c_S_WAIT;
                r_cnt[i]   <= c_RESP_W'(i * c_STAGGER);
                r_life[i]  <= '0;
                r_rx[i]    <= '0;
                r_ry[i]    <= '0;
                r_mode[i]  <= '0;
            end else begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
                r_life[i]  <= w_life_nxt[i];
                r_rx[i]    <= w_rx_nxt[i];
                r_ry[i]    <= w_ry_nxt[i];
                r_mode[i]  <= w_mode_nxt[i];
            end
        end
    end

    always_comb begin
        w_pix = 8'h00;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (w_cover[i])
                w_pix = mode_color(r_mode[i]);
        end
    end

    // A new grant overwrites mode and reloads the timer
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_timer[0]    <= '0;
            r_timer[1]    <= '0;
            r_eff_mode    <= '0;
            r_grant_pulse <= '0;
            r_pixel       <= '0;
        end else begin
            r_pixel       <= w_pix;
            r_grant_pulse <= 2'b00;
            for (int p = 0; p < 2; p++) begin
                if (w_grant && (last_hitter == 1'(p))) begin
                    r_timer[p]           <= c_EFF_W'(EFFECT_FRAMES);
                    r_eff_mode[2*p +: 2] <= w_grant_mode;
                    r_grant_pulse[p]     <= 1'b1;
                end else if (frame_tick && (r_timer[p] != '0)) begin
                    r_timer[p] <= r_timer[p] - c_EFF_W'(1);
                end
            end
        end
    end

    assign pixel       = r_pixel;
    assign eff_active  = {(r_timer[1] != '0), (r_timer[0] != '0)};
    assign eff_mode    = r_eff_mode;
    assign grant_pulse = r_grant_pulse;

endmodule
`default_nettype wire

// File: tb/tb_power_pack_mgr.sv
`default_nettype none
// ============================================================================
// Module   : tb_power_pack_mgr
// Brief    : Self-checking bench for power_pack_mgr: placement table, directed
//            corner sequences and a randomized run against a reference model.
// Revision : 1.0
// ============================================================================
module tb_power_pack_mgr;
    localparam int NS   = 2;
    localparam int W    = 20;
    localparam int H    = 20;
    localparam int RESP = 120;
    localparam int EFF  = 300;
    localparam int LIFE = 600;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        frame_tick = 1'b0;
    logic [20:0] rand_in = '0;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic [10:0] ball_x = 11'd2000;
    logic [9:0]  ball_y = '0;
    logic [5:0]  ball_size = 6'd1;
    logic        last_hitter = 1'b0;
    logic [7:0]  pixel;
    logic [1:0]  eff_active;
    logic [3:0]  eff_mode;
    logic [1:0]  grant_pulse;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    power_pack_mgr dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .rand_in(rand_in),
        .hcount(hcount), .vcount(vcount), .ball_x(ball_x), .ball_y(ball_y),
        .ball_size(ball_size), .last_hitter(last_hitter), .pixel(pixel),
        .eff_active(eff_active), .eff_mode(eff_mode), .grant_pulse(grant_pulse)
    );

    function automatic logic [7:0] color_of(input int m);
        case (m)
            0:       return 8'h03;
            1:       return 8'h16;
            2:       return 8'hE3;
            default: return 8'hF0;
        endcase
    endfunction

    // Reference model: phases 0=waiting, 1=ready to place, 2=on screen
    int m_phase[NS], m_cnt[NS], m_life[NS], m_rx[NS], m_ry[NS], m_mode[NS];
    int m_timer[2], m_emode[2];
    logic [1:0] m_gp;
    logic [7:0] m_pix;

    always @(posedge clk) begin
        bit placed, granted;
        int bx, by, bs, who;
        if (!reset) begin
            for (int s = 0; s < NS; s++) begin
                m_phase[s] = 0; m_cnt[s] = s * (RESP / NS); m_life[s] = 0;
                m_rx[s] = 0; m_ry[s] = 0; m_mode[s] = 0;
            end
            m_timer = '{0, 0}; m_emode = '{0, 0}; m_gp = 2'b00; m_pix = 8'h00;
        end else begin
            m_pix = 8'h00;
            for (int s = NS - 1; s >= 0; s--)
                if (m_phase[s] == 2 && int'(hcount) >= m_rx[s] && int'(hcount) < m_rx[s] + W &&
                    int'(vcount) >= m_ry[s] && int'(vcount) < m_ry[s] + H)
                    m_pix = color_of(m_mode[s]);
            if (frame_tick)
                for (int p = 0; p < 2; p++) if (m_timer[p] > 0) m_timer[p]--;
            m_gp = 2'b00; placed = 0; granted = 0;
            bx = int'(ball_x); by = int'(ball_y); bs = int'(ball_size); who = int'(last_hitter);
            for (int s = 0; s < NS; s++) begin
                if (m_phase[s] == 0) begin
                    if (m_cnt[s] == 0) m_phase[s] = 1;
                    else if (frame_tick) m_cnt[s]--;
                end else if (m_phase[s] == 1) begin
                    if (!placed) begin
                        placed = 1;
                        m_mode[s] = int'(rand_in) % 4;
                        m_rx[s] = int'(rand_in) / 1024;
                        if (m_rx[s] > 1024 - W) m_rx[s] -= 512;
                        m_ry[s] = int'(rand_in) % 1024;
                        if (m_ry[s] > 768 - H) m_ry[s] -= 384;
                        m_life[s] = LIFE; m_phase[s] = 2;
                    end
                end else if (frame_tick) begin
                    if (bx < m_rx[s] + W && bx + bs > m_rx[s] && by < m_ry[s] + H && by + bs > m_ry[s]) begin
                        m_phase[s] = 0; m_cnt[s] = RESP;
                        if (!granted) begin
                            granted = 1; m_timer[who] = EFF; m_emode[who] = m_mode[s]; m_gp[who] = 1'b1;
                        end
                    end else begin
                        m_life[s]--;
                        if (m_life[s] == 0) begin m_phase[s] = 0; m_cnt[s] = RESP; end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] exp_v, act_v;
        if (chk_en) begin
            exp_v = {m_pix, m_timer[1] != 0, m_timer[0] != 0, 2'(m_emode[1]), 2'(m_emode[0]), m_gp};
            act_v = {pixel, eff_active, eff_mode, grant_pulse};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL model t=%0t {pixel,active,mode,pulse} actual=%h expected=%h", $time, act_v, exp_v);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            frame_tick = 1'b1; @(negedge clk);
            frame_tick = 1'b0; @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; frame_tick = 1'b0;
        cyc(2);
        chk("reset_outputs", {pixel, eff_active, eff_mode, grant_pulse}, 0);
        chk_en = 1'b1;
        reset = 1'b1;
    endtask

    task automatic ball_away();
        ball_x = 11'd2000; ball_y = 10'd0; ball_size = 6'd1;
    endtask

    task automatic probe(input int x, input int y);
        hcount = 11'(x); vcount = 10'(y);
        cyc(1);
    endtask

    typedef struct {
        logic [10:0] rxr;
        logic [9:0]  ryr;
        int          ex;
        int          ey;
        logic [7:0]  col;
    } place_t;

    place_t tbl[6];

    initial begin
        int n, s;
        tbl[0] = '{11'd1020, 10'd760,  508, 376, 8'h03};
        tbl[1] = '{11'd1004, 10'd748, 1004, 748, 8'h03};
        tbl[2] = '{11'd100,  10'd201,  100, 201, 8'h16};
        tbl[3] = '{11'd1005, 10'd749,  493, 365, 8'h16};
        tbl[4] = '{11'd0,    10'd2,      0,   2, 8'hE3};
        tbl[5] = '{11'd2047, 10'd1023, 1535, 639, 8'hF0};

        // Placement, clamping, colour and pixel bounds (slot 0 spawns with no ticks)
        foreach (tbl[k]) begin
            ball_away();
            do_reset();
            rand_in = {tbl[k].rxr, tbl[k].ryr};
            cyc(3);
            probe(tbl[k].ex, tbl[k].ey);           chk("place_corner", pixel, tbl[k].col);
            probe(tbl[k].ex + 19, tbl[k].ey + 19); chk("place_far",    pixel, tbl[k].col);
            probe(tbl[k].ex + 20, tbl[k].ey);      chk("place_xedge",  pixel, 0);
            probe(tbl[k].ex, tbl[k].ey + 20);      chk("place_yedge",  pixel, 0);
        end

        // Pickup by player 2; effect lasts exactly EFF ticks
        do_reset();
        rand_in = {11'd200, 10'd300};
        cyc(3);
        ball_x = 11'd190; ball_y = 10'd295; ball_size = 6'd12; last_hitter = 1'b1;
        frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
        chk("p2_grant_pulse", grant_pulse, 2'b10);
        chk("p2_active", eff_active, 2'b10);
        cyc(1);
        chk("p2_pulse_drop", grant_pulse, 2'b00);
        ball_away();
        n = 0;
        while (eff_active[1] && n < 400) begin tick(1); n++; end
        chk("p2_effect_len", n, EFF);

        // Touching edge is not a pickup; untouched pack expires after LIFE ticks
        do_reset();
        rand_in = {11'd200, 10'd300};
        cyc(3);
        rand_in = {11'd600, 10'd500};
        ball_x = 11'd188; ball_y = 10'd300; ball_size = 6'd12; last_hitter = 1'b0;
        hcount = 11'd200; vcount = 10'd300;
        frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
        chk("touch_no_pulse", grant_pulse, 2'b00);
        cyc(1);
        chk("touch_still_live", pixel, 8'h03);
        ball_away();
        n = 1;
        while (pixel == 8'h03 && n < 700) begin tick(1); n++; end
        chk("expire_len", n, LIFE);
        chk("expire_no_effect", eff_active, 2'b00);

        // Stagger, then simultaneous pickup of two packs
        do_reset();
        rand_in = {11'd200, 10'd301};
        cyc(3);
        rand_in = {11'd205, 10'd303};
        hcount = 11'd224; vcount = 10'd322;
        tick(59); cyc(3);
        chk("stagger_early", pixel, 0);
        tick(1); cyc(3);
        chk("stagger_spawn", pixel, 8'hF0);
        ball_x = 11'd195; ball_y = 10'd295; ball_size = 6'd20; last_hitter = 1'b0;
        hcount = 11'd210; vcount = 10'd310;
        frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
        chk("dual_pulse", grant_pulse, 2'b01);
        chk("dual_mode", eff_mode, 4'b0001);
        cyc(1);
        chk("dual_pulse_drop", grant_pulse, 2'b00);
        chk("dual_cleared", pixel, 0);

        // Overwrite of an active effect, then reset mid-effect
        ball_away();
        rand_in = {11'd400, 10'd402};
        tick(200);
        chk("p1_remaining", eff_active, 2'b01);
        ball_x = 11'd395; ball_y = 10'd395; ball_size = 6'd20; last_hitter = 1'b0;
        frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
        chk("overwrite_mode", eff_mode[1:0], 2'b10);
        chk("overwrite_pulse", grant_pulse, 2'b01);
        ball_away();
        tick(150);
        chk("reload_timer", eff_active, 2'b01);
        reset = 1'b0; cyc(1);
        chk("reset_mid_active", eff_active, 2'b00);
        chk("reset_mid_mode", eff_mode, 4'b0000);
        reset = 1'b1;

        // Randomized run against the model
        for (int c = 0; c < 16000; c++) begin
            frame_tick  = ($urandom_range(0, 2) == 0);
            rand_in     = 21'($urandom);
            last_hitter = 1'($urandom);
            ball_size   = 6'($urandom_range(1, 40));
            reset       = ($urandom_range(0, 4999) != 0);
            s = $urandom_range(0, NS - 1);
            if ($urandom_range(0, ((c / 4000) % 2 == 0) ? 3 : 63) == 0) begin
                ball_x = 11'(m_rx[s] - int'(ball_size) + $urandom_range(0, W + int'(ball_size)));
                ball_y = 10'(m_ry[s] - int'(ball_size) + $urandom_range(0, H + int'(ball_size)));
            end else begin
                ball_x = 11'($urandom_range(0, 1100));
                ball_y = 10'($urandom_range(0, 800));
            end
            if ($urandom_range(0, 1) == 0) begin
                hcount = 11'(m_rx[s] - 1 + $urandom_range(0, W + 1));
                vcount = 10'(m_ry[s] - 1 + $urandom_range(0, H + 1));
            end else begin
                hcount = 11'($urandom_range(0, 1600));
                vcount = 10'($urandom_range(0, 1023));
            end
            cyc(1);
        end
        reset = 1'b1; frame_tick = 1'b0;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
